// File: rtl/i2c_regmap_if.sv
// Byte-level link between the I2C slave (SCL domain) and the register file.
interface i2c_regmap_if;
  logic       i2c_start;
  logic       i2c_stop;
  logic       i2c_r_w;
  logic       i2c_data_vld;
  logic [7:0] i2c_data_out;
  logic [7:0] i2c_data_in;
  logic       i2c_ready;

  modport master (
    output i2c_start, i2c_stop, i2c_r_w, i2c_data_vld, i2c_data_out,
    input  i2c_data_in, i2c_ready
  );

  modport slave (
    input  i2c_start, i2c_stop, i2c_r_w, i2c_data_vld, i2c_data_out,
    output i2c_data_in, i2c_ready
  );
endinterface

// File: rtl/i2c_regmap.sv
// Pointer-then-data register file behind the I2C slave, with auto-increment.
// Define I2C_REGMAP_RO_ID_EN to make register 0 a read-only ID (ID_VAL).
module i2c_regmap #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned PTR_W    = 4,
  parameter logic [7:0]  REG_RST  = 8'h00,
  parameter logic [7:0]  ID_VAL   = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst,
  i2c_regmap_if.slave             bus,
  output logic                    wr_pulse,
  output logic [PTR_W-1:0]        wr_addr,
  output logic [NUM_REGS*8-1:0]   reg_q,
  output logic [PTR_W-1:0]        ptr_q
);

`ifdef I2C_REGMAP_RO_ID_EN
  localparam logic RO_ID = 1'b1;
`else
  localparam logic RO_ID = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, PTR, DATA} state_t;

  state_t            state_q, state_d;
  logic [2:0]        start_sync_q, start_sync_d;
  logic [2:0]        stop_sync_q, stop_sync_d;
  logic [2:0]        vld_sync_q, vld_sync_d;
  logic [1:0]        rw_sync_q, rw_sync_d;
  logic [7:0]        regs_q [NUM_REGS];
  logic [7:0]        regs_d [NUM_REGS];
  logic [PTR_W-1:0]  ptr_d;
  logic              wr_pulse_q, wr_pulse_d;
  logic [PTR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [7:0]        data_in_q, data_in_d;
  logic              ready_q, ready_d;
  logic              start_ev, stop_ev, byte_ev, rw_s;

  assign start_ev = start_sync_q[1] & ~start_sync_q[2];
  assign stop_ev  = stop_sync_q[1]  & ~stop_sync_q[2];
  assign byte_ev  = ~vld_sync_q[1]  &  vld_sync_q[2];
  assign rw_s     = rw_sync_q[1];

  always_comb begin
    start_sync_d = {start_sync_q[1:0], bus.i2c_start};
    stop_sync_d  = {stop_sync_q[1:0],  bus.i2c_stop};
    vld_sync_d   = {vld_sync_q[1:0],   bus.i2c_data_vld};
    rw_sync_d    = {rw_sync_q[0],      bus.i2c_r_w};
    ready_d      = 1'b1;
    data_in_d    = (RO_ID && ptr_q == '0) ? ID_VAL : regs_q[ptr_q];
  end

  // Byte handling uses the pre-event state; start/stop override the next state
  // afterwards, start last so it wins over a same-cycle stop.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    regs_d     = regs_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    if (byte_ev && state_q != IDLE) begin
      if (rw_s) begin
        ptr_d   = ptr_q + 1'b1;
        state_d = DATA;
      end else if (state_q == PTR) begin
        ptr_d   = bus.i2c_data_out[PTR_W-1:0];
        state_d = DATA;
      end else begin
        if (!(RO_ID && ptr_q == '0)) begin
          regs_d[ptr_q] = bus.i2c_data_out;
          wr_pulse_d    = 1'b1;
          wr_addr_d     = ptr_q;
        end
        ptr_d = ptr_q + 1'b1;
      end
    end
    if (stop_ev)  state_d = IDLE;
    if (start_ev) state_d = PTR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      start_sync_q <= '0;
      stop_sync_q  <= '0;
      vld_sync_q   <= '0;
      rw_sync_q    <= '0;
      regs_q       <= '{default: REG_RST};
      ptr_q        <= '0;
      wr_pulse_q   <= 1'b0;
      wr_addr_q    <= '0;
      data_in_q    <= '0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_sync_q <= start_sync_d;
      stop_sync_q  <= stop_sync_d;
      vld_sync_q   <= vld_sync_d;
      rw_sync_q    <= rw_sync_d;
      regs_q       <= regs_d;
      ptr_q        <= ptr_d;
      wr_pulse_q   <= wr_pulse_d;
      wr_addr_q    <= wr_addr_d;
      data_in_q    <= data_in_d;
      ready_q      <= ready_d;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      reg_q[8*k +: 8] = regs_q[k];
    end
    if (RO_ID) reg_q[7:0] = ID_VAL;
  end

  assign wr_pulse        = wr_pulse_q;
  assign wr_addr         = wr_addr_q;
  assign bus.i2c_data_in = data_in_q;
  assign bus.i2c_ready   = ready_q;

endmodule
